// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control encodings: next-PC selects, FSM states and guard default.
// Imported by pipe_ctrl and by the IF/ID stage logic.
package pipe_ctrl_pkg;

  localparam int unsigned GUARD_CYCLES_DEF = 3;

  localparam logic [2:0] PCS_SEQ = 3'd0;
  localparam logic [2:0] PCS_BR  = 3'd1;
  localparam logic [2:0] PCS_JMP = 3'd2;
  localparam logic [2:0] PCS_JR  = 3'd3;
  localparam logic [2:0] PCS_IRQ = 3'd4;
  localparam logic [2:0] PCS_EXC = 3'd5;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_GUARD = 1'b1;

  typedef struct packed {
    logic       pc_we;
    logic [2:0] pc_src;
    logic       if_id_we;
    logic       if_id_flush;
    logic       id_flush;
    logic       irq_ack;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/trap controller: zero-latency steering of PC and stage registers,
// with a guard window after each trap that masks further exceptions and IRQs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = GUARD_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        mem_busy,
  input  logic        branch_taken,
  input  logic        jflush,
  input  logic        jump_is_jr,
  input  logic        exception,
  input  logic        bubble,
  input  logic        irq,
  input  logic        id_pc31,
  input  logic [31:0] id_pc_plus4,
  output logic        pc_we,
  output logic [2:0]  pc_src,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_flush,
  output logic        irq_ack,
  output logic [31:0] epc,
  output logic        in_guard
);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        irq_pend_q, irq_pend_d;
  logic [31:0] epc_q, epc_d;
  ctrl_t       ctrl;
  logic        in_run;
  logic        irq_take;

  always_comb begin
    ctrl       = '0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    epc_d      = epc_q;
    in_run     = (state_q == ST_RUN);
    irq_take   = 1'b0;

    // Guard countdown runs on every unfrozen cycle; traps cannot fire in GUARD.
    if (!mem_busy && state_q == ST_GUARD) begin
      if (cnt_q == 4'd0) state_d = ST_RUN;
      else               cnt_d   = cnt_q - 4'd1;
    end

    if (mem_busy) begin
      ctrl = '0;
    end else if (branch_taken) begin
      ctrl.pc_we       = 1'b1;
      ctrl.pc_src      = PCS_BR;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_flush    = 1'b1;
    end else if (exception && in_run) begin
      ctrl.pc_we       = 1'b1;
      ctrl.pc_src      = PCS_EXC;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_flush    = 1'b1;
      epc_d            = id_pc_plus4;
      state_d          = ST_GUARD;
      cnt_d            = 4'(GUARD_CYCLES - 1);
    end else if (irq_pend_q && !id_pc31 && !bubble && !jflush && in_run) begin
      // Return to the interrupted ID instruction itself, hence PC+4 minus 4.
      irq_take         = 1'b1;
      ctrl.pc_we       = 1'b1;
      ctrl.pc_src      = PCS_IRQ;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_flush    = 1'b1;
      ctrl.irq_ack     = 1'b1;
      epc_d            = id_pc_plus4 - 32'd4;
      state_d          = ST_GUARD;
      cnt_d            = 4'(GUARD_CYCLES - 1);
    end else if (jflush) begin
      ctrl.pc_we       = 1'b1;
      ctrl.pc_src      = jump_is_jr ? PCS_JR : PCS_JMP;
      ctrl.if_id_flush = 1'b1;
    end else if (bubble) begin
      ctrl.id_flush    = 1'b1;
    end else begin
      ctrl.pc_we       = 1'b1;
      ctrl.pc_src      = PCS_SEQ;
      ctrl.if_id_we    = 1'b1;
    end

    // Taking the IRQ consumes the pending flag even if irq is still asserted.
    irq_pend_d = irq_take ? 1'b0 : (irq_pend_q | (irq & ~id_pc31));
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= ST_RUN;
      cnt_q      <= 4'd0;
      irq_pend_q <= 1'b0;
      epc_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      irq_pend_q <= irq_pend_d;
      epc_q      <= epc_d;
    end
  end

  assign pc_we       = reset_b & ctrl.pc_we;
  assign pc_src      = reset_b ? ctrl.pc_src : PCS_SEQ;
  assign if_id_we    = reset_b & ctrl.if_id_we;
  assign if_id_flush = reset_b & ctrl.if_id_flush;
  assign id_flush    = reset_b & ctrl.id_flush;
  assign irq_ack     = reset_b & ctrl.irq_ack;
  assign epc         = epc_q;
  assign in_guard    = (state_q == ST_GUARD);

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 3, giving the number of cycles after a trap during which IRQ and exception are masked (legal range 1..15).
REQ-002 SHALL have ports, clock and reset first:
  - clk  in  1  single system clock, rising edge.
  - reset_b  in  1  asynchronous, active-low reset.
  - mem_busy  in  1  memory stall; freezes the whole pipeline.
  - branch_taken  in  1  EX-stage branch resolved taken.
  - jflush  in  1  ID-stage j/jal/jr/jalr decoded.
  - jump_is_jr  in  1  qualifies jflush: 1 = register jump.
  - exception  in  1  ID-stage undefined-instruction trap.
  - bubble  in  1  ID-stage load-use hazard.
  - irq  in  1  external interrupt, level.
  - id_pc31  in  1  supervisor bit of the ID-stage PC; 1 masks IRQ.
  - id_pc_plus4  in  32  PC+4 of the ID-stage instruction.
  - pc_we  out  1  PC register write enable.
  - pc_src  out  3  next-PC select: 0 seq, 1 branch, 2 jump, 3 jr, 4 irq vector, 5 exception vector.
  - if_id_we  out  1  IF/ID write enable.
  - if_id_flush  out  1  zero IF/ID.
  - id_flush  out  1  zero ID/EX (bubble insert).
  - irq_ack  out  1  one-cycle IRQ acceptance pulse.
  - epc  out  32  registered return address.
  - in_guard  out  1  1 while in state GUARD.

Function
REQ-003 SHALL implement a two-state FSM, RUN and GUARD, plus a 4-bit guard counter, an irq_pend flag and the epc register.
REQ-004 SHALL drive pc_we, pc_src, if_id_we, if_id_flush, id_flush and irq_ack combinationally from the current state and inputs (zero-latency decision); epc, state, counter and irq_pend SHALL update on the clk rising edge.
REQ-005 SHALL set irq_pend on any edge where irq=1 and id_pc31=0, and SHALL clear it only on the edge where the IRQ is taken; deasserting irq SHALL NOT clear a set irq_pend.
REQ-006 SHALL resolve each cycle by strict priority, first match wins:
  (a) mem_busy: all outputs 0; no register changes except irq_pend.
  (b) branch_taken: pc_we=1, pc_src=1, if_id_flush=1, id_flush=1; ID-stage events are ignored as wrong-path.
  (c) exception, in RUN only: pc_we=1, pc_src=5, if_id_flush=1, id_flush=1; epc<=id_pc_plus4; go to GUARD.
  (d) irq_pend & ~id_pc31 & ~bubble & ~jflush, in RUN only: pc_we=1, pc_src=4, if_id_flush=1, id_flush=1, irq_ack=1; epc<=id_pc_plus4-4; go to GUARD.
  (e) jflush: pc_we=1, pc_src = jump_is_jr ? 3 : 2, if_id_flush=1, if_id_we=0.
  (f) bubble: pc_we=0, if_id_we=0, id_flush=1.
  (g) otherwise: pc_we=1, pc_src=0, if_id_we=1.
REQ-007 SHALL load the counter with GUARD_CYCLES-1 on entry to GUARD, decrement it each GUARD cycle that is not frozen by mem_busy, and return to RUN on the edge where the counter is 0.
REQ-008 SHALL ignore exception and not take IRQs while in GUARD; a pending IRQ SHALL remain pending.
REQ-009 SHALL apply rules (b), (e), (f) and (g) unchanged in GUARD.
REQ-010 SHALL compute epc arithmetic modulo 2^32; id_pc_plus4=0 yields epc=32'hFFFF_FFFC for an IRQ.

Reset
REQ-011 SHALL, while reset_b=0, force state=RUN, counter=0, irq_pend=0, epc=0 and all combinational outputs to 0, independent of clk.
REQ-012 SHALL abandon any GUARD or pending IRQ on reset assertion mid-operation and resume in RUN with normal sequencing on the first edge after release.

Structure
REQ-013 SHALL take the pc_src encodings (PCS_SEQ..PCS_EXC), the state encoding and the GUARD_CYCLES default from shared package pipe_ctrl_pkg, which IF and ID also import.
REQ-014 SHALL be a single module with the guard counter inline; no sub-module.

Verification
REQ-015 Bubble=1 for 1 cycle with no other events -> pc_we=0, if_id_we=0, id_flush=1 that cycle only.
REQ-016 Branch_taken=1 with exception=1 in the same cycle -> pc_src=1 and epc unchanged; state stays RUN.
REQ-017 Irq pulse (1 cycle) with id_pc31=0 while jflush=1, then a clean cycle with id_pc_plus4=32'h0000_0108 -> jump is taken first; next cycle pc_src=4, irq_ack=1, epc=32'h0000_0104; in_guard=1 for 3 cycles.
REQ-018 Exception with id_pc_plus4=32'h0000_0040, then irq held high -> pc_src=5, epc=32'h0000_0040; IRQ is taken only after in_guard falls.
REQ-019 mem_busy=1 for 2 cycles during GUARD -> all outputs 0; GUARD lasts 3+2 cycles total.
REQ-020 reset_b dropped while in GUARD with irq_pend set -> outputs 0 asynchronously; after release, normal sequencing (pc_src=0) with no irq_ack until irq is reasserted.
